// File: rtl/sevenseg_scan.sv
// sevenseg_scan: multi-digit scanner feeding a single seven-segment decoder.
// One nibble plus its decimal point is presented per slot, with active-low
// digit enables, a blank window at the start of every slot, tear-free value
// updates at frame boundaries and optional leading-zero blanking.
//
// Load handshake: `load` is a one-cycle strobe with no back-pressure; the
// block always accepts it. On the sampling edge `digits_in`/`dp_in` are
// captured into the pending register. If that edge is also the frame wrap
// edge (or scanning is disabled), the values go straight to the display register.
module sevenseg_scan #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lzb_en,
  output logic                  out_a,
  output logic                  out_b,
  output logic                  out_c,
  output logic                  out_d,
  output logic                  out_dp,
  output logic [N_DIGITS-1:0]   an,
  output logic [2:0]            digit_idx,
  output logic                  frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [2:0]    IDX_LAST  = 3'(N_DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [4*N_DIGITS-1:0] pend;
  logic [4*N_DIGITS-1:0] disp;
  logic [N_DIGITS-1:0]   pend_dp;
  logic [N_DIGITS-1:0]   dp_disp;

  logic                  slot_end;
  logic                  wrap;
  logic                  zero_run;
  logic                  show;
  logic [N_DIGITS-1:0]   blank_vec;
  logic [N_DIGITS-1:0]   an_next;
  logic [3:0]            cur_nib;
  logic                  cur_dp;

  assign slot_end = en && (cnt == CNT_LAST);
  assign wrap     = slot_end && (digit_idx == IDX_LAST);

  // Prescaler and slot index; both hold while scanning is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= '0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        digit_idx <= wrap ? 3'd0 : digit_idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pending register captures every load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      pend_dp <= '0;
    end else if (load) begin
      pend    <= digits_in;
      pend_dp <= dp_in;
    end
  end

  // Display register only changes between frames (or when idle), with load bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp    <= '0;
      dp_disp <= '0;
    end else if (wrap || !en) begin
      disp    <= load ? digits_in : pend;
      dp_disp <= load ? dp_in : pend_dp;
    end
  end

  // Current digit selection, leading-zero mask and next digit enables.
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    an_next   = '1;
    show      = en && (cnt >= BLANK_END);
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp[4*k +: 4] == 4'h0);
      if (k != 0) begin
        blank_vec[k] = lzb_en && zero_run && !dp_disp[k];
      end
      if (digit_idx == 3'(k)) begin
        cur_nib = disp[4*k +: 4];
        cur_dp  = dp_disp[k];
      end
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      an_next[k] = !(show && (digit_idx == 3'(k)) && !blank_vec[k]);
    end
  end

  // Registered decoder drive, digit enables and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      {out_a, out_b, out_c, out_d} <= 4'h0;
      out_dp     <= 1'b0;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      {out_a, out_b, out_c, out_d} <= cur_nib;
      out_dp     <= cur_dp;
      an         <= an_next;
      frame_done <= wrap;
    end
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Multi-digit display scanner that sits directly upstream of the `sevenseg` decoder.
- Holds an N-digit value and time-multiplexes one 4-bit nibble at a time onto the decoder inputs (`out_a`..`out_d`, MSB first), plus that digit's decimal point.
- Drives active-low digit enables.
- Provides tear-free value updates, inter-digit blanking (anti-ghosting) and optional leading-zero blanking.

Parameters:
- `N_DIGITS`, 4, number of digits scanned (legal range 2..8).
- `SCAN_DIV`, 100000, clock cycles per digit slot (must be > `BLANK_CYC`).
- `BLANK_CYC`, 16, cycles at the start of each slot with all digits off.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable; 0 freezes scanning and blanks all digits.
- `load`  in  1  one-cycle strobe; latches `digits_in`/`dp_in` into the pending register.
- `digits_in`  in  4*N_DIGITS  packed nibbles; `[3:0]` is digit 0 (rightmost).
- `dp_in`  in  N_DIGITS  decimal point per digit; bit k belongs to digit k.
- `lzb_en`  in  1  leading-zero blanking enable.
- `out_a`  out  1  nibble bit 3 (MSB) to decoder `in_a`.
- `out_b`  out  1  nibble bit 2.
- `out_c`  out  1  nibble bit 1.
- `out_d`  out  1  nibble bit 0 (LSB).
- `out_dp`  out  1  decimal point for the current digit.
- `an`  out  N_DIGITS  digit enables, active low; `an[k]` is digit k.
- `digit_idx`  out  3  index of the slot being scanned.
- `frame_done`  out  1  one-cycle pulse when the index wraps from `N_DIGITS-1` to 0.

Behaviour:
- Clock and reset: single clock domain (`clk`); reset `rst` is synchronous, active-high.
- Reset values: every output and register is cleared, except `an`.
  - Cleared to 0: pending and display registers, prescaler `cnt`, `digit_idx`, `out_a`..`out_d`, `out_dp`, `frame_done`.
  - `an` resets to all ones (all digits off).
  - Reset mid-frame takes effect on the next edge and overrides all other inputs.
- Prescaler and slot advance:
  - With `en`=1, `cnt` counts 0..`SCAN_DIV-1`.
  - At `SCAN_DIV-1`, `cnt` returns to 0 and `digit_idx` increments, wrapping `N_DIGITS-1` -> 0.
  - `frame_done`=1 for exactly the cycle after that wrap edge.
- Enable low: with `en`=0, `cnt` and `digit_idx` hold, `frame_done`=0, and `an` is registered to all ones. When `en` returns, scanning resumes from the held `cnt`.
- Value update (tear-free):
  - `load`=1 captures the inputs into the pending register.
  - Pending is copied to the display register on the edge where `digit_idx` wraps to 0, and on every edge while `en`=0.
  - If `load` and the wrap happen on the same edge, the display register takes the new input values directly (bypass).
  - Loads mid-frame never change digits already scanned or remaining in the current frame.
- Output registration: `out_a`..`out_d`, `out_dp` and `an` are registered from the current `(cnt, digit_idx)`, i.e. one clock of latency relative to counter state.
  - Nibble and dp are `disp[digit_idx]` / `dp_disp[digit_idx]`.
  - `an` is all ones while `cnt` < `BLANK_CYC`.
  - Otherwise `an` has only bit `digit_idx` low, unless that digit is blanked.
- Leading-zero blanking: with `lzb_en`=1, digit k (k ≥ 1) is blanked (its `an` bit stays high for the whole slot) when digit k and all higher digits equal 0 and `dp_disp[k]`=0.
  - Digit 0 is never blanked.
  - The blanking test uses display-register contents only.
- Nibble range: values A..F pass through unchanged; the decoder handles them.
- Overlap: at most one `an` bit is ever low; no glitch on `an` at slot boundaries.

Test Plan:
(Use `N_DIGITS`=4, `SCAN_DIV`=8, `BLANK_CYC`=2.)
1. Reset: hold `rst`=1 for 3 cycles with `en`=1 -> `an`=4'b1111, nibble 0, `out_dp`=0, `digit_idx`=0, `frame_done`=0. After release, the first slot shows `an`=1110 with nibble 0 from cycle 3 to cycle 8 of the slot.
2. Basic scan: `load` with 16'h1234 and `dp_in`=4'b0010 -> after the next wrap, the following sequence repeats and `frame_done` pulses every 32 cycles:
   - slot 0: `an`=1110, nibble 4, dp 0
   - slot 1: `an`=1101, nibble 3, dp 1
   - slot 2: `an`=1011, nibble 2
   - slot 3: `an`=0111, nibble 1
   - 2 blank cycles precede each slot.
3. Leading-zero blanking: `load` 16'h0050 with `lzb_en`=1 -> digits 3 and 2 keep `an`=1111 for the whole slot; slot 1 shows 1101 nibble 5; slot 0 shows 1110 nibble 0. Repeat with `dp_in`=4'b0100 -> digit 2 is shown as nibble 0 with dp 1.
4. Mid-frame load: with 16'h1234 displayed, `load` 16'hABCD during slot 1 -> slots 2 and 3 still show 2 and 1; from the next slot 0 the display shows D, C, B, A. Also verify `load` on the exact wrap edge shows the new value in that same frame.
5. Enable low: drop `en` at `cnt`=5 of slot 2 for 10 cycles -> `an`=1111 one cycle later, `cnt`/`digit_idx` frozen, no `frame_done`. On re-enable, slot 2 completes its remaining 2 counts (`cnt` 6..7), then advances to slot 3.
6. Reset mid-operation: assert `rst` during slot 3 -> next edge gives all reset values. After release with no `load`, the display shows nibble 0 on all four digits (`lzb_en`=0).
